// File: rtl/decoder_1x2_arbiter.sv
// Two-requester round-robin arbiter driving one-hot grants as a 1-to-2 decode
// of a registered owner select, with optional bounded-hold preemption.
module decoder_1x2_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy,
  output logic preempt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_own, req_oth;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    req_own   = sel_q ? req1 : req0;
    req_oth   = sel_q ? req0 : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // A tie goes to the priority pointer, otherwise to the lone requester.
          sel_d   = (req0 && req1) ? prio_q : req1;
          cnt_d   = CNT_ONE;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_own) begin
          state_d = IDLE;
          prio_d  = ~sel_q;
          cnt_d   = '0;
        end else if (PREEMPT_EN && (cnt_q == HOLD_MAX) && req_oth) begin
          state_d   = IDLE;
          prio_d    = ~sel_q;
          cnt_d     = '0;
          preempt_d = 1'b1;
        end else if (PREEMPT_EN && (cnt_q != HOLD_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign busy    = (state_q == GRANT);
  assign gnt0    = busy & ~sel_q;
  assign gnt1    = busy & sel_q;
  assign sel     = sel_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_decoder_1x2_arbiter.sv
// Scoreboard bench: three arbiters (MAX_HOLD 8, 0, 3) checked against a cycle model.
module tb_decoder_1x2_arbiter;

  logic clk;
  logic rst;
  logic r0 [3];
  logic r1 [3];
  logic g0 [3];
  logic g1 [3];
  logic sl [3];
  logic bz [3];
  logic pe [3];

  int n_total = 0;
  int n_bad   = 0;

  decoder_1x2_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_h8 (
    .clk(clk), .rst(rst), .req0(r0[0]), .req1(r1[0]),
    .gnt0(g0[0]), .gnt1(g1[0]), .sel(sl[0]), .busy(bz[0]), .preempt(pe[0]));
  decoder_1x2_arbiter #(.MAX_HOLD(0), .CNT_W(4)) u_h0 (
    .clk(clk), .rst(rst), .req0(r0[1]), .req1(r1[1]),
    .gnt0(g0[1]), .gnt1(g1[1]), .sel(sl[1]), .busy(bz[1]), .preempt(pe[1]));
  decoder_1x2_arbiter #(.MAX_HOLD(3), .CNT_W(4)) u_h3 (
    .clk(clk), .rst(rst), .req0(r0[2]), .req1(r1[2]),
    .gnt0(g0[2]), .gnt1(g1[2]), .sel(sl[2]), .busy(bz[2]), .preempt(pe[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state, one slot per instance
  int   mh [3] = '{8, 0, 3};
  bit   m_busy [3];
  bit   m_own  [3];
  bit   m_prio [3];
  bit   m_pre  [3];
  int   m_run  [3];
  logic [14:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit do_rst);
    bit a, b, mine, theirs;
    for (int i = 0; i < 3; i++) begin
      if (do_rst) begin
        m_busy[i] = 0; m_own[i] = 0; m_prio[i] = 0; m_run[i] = 0; m_pre[i] = 0;
      end else begin
        a = r0[i]; b = r1[i];
        m_pre[i] = 0;
        if (!m_busy[i]) begin
          if (a || b) begin
            m_own[i]  = (a && b) ? m_prio[i] : b;
            m_busy[i] = 1;
            m_run[i]  = 1;
          end
        end else begin
          mine   = m_own[i] ? b : a;
          theirs = m_own[i] ? a : b;
          if (!mine) begin
            m_busy[i] = 0; m_prio[i] = ~m_own[i]; m_run[i] = 0;
          end else if (mh[i] > 0 && m_run[i] >= mh[i] && theirs) begin
            m_busy[i] = 0; m_prio[i] = ~m_own[i]; m_run[i] = 0; m_pre[i] = 1;
          end else begin
            m_run[i]++;
          end
        end
      end
    end
  endtask

  function automatic logic [14:0] model_vec();
    logic [14:0] v;
    for (int i = 0; i < 3; i++)
      v[5*i +: 5] = {m_busy[i] & ~m_own[i], m_busy[i] & m_own[i], m_own[i], m_busy[i], m_pre[i]};
    return v;
  endfunction

  task automatic compare_out();
    logic [14:0] e;
    string nm;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      nm = $sformatf("i%0d", i);
      check_eq({nm, "_gnt0"},    32'(g0[i]), 32'(e[5*i+4]));
      check_eq({nm, "_gnt1"},    32'(g1[i]), 32'(e[5*i+3]));
      check_eq({nm, "_sel"},     32'(sl[i]), 32'(e[5*i+2]));
      check_eq({nm, "_busy"},    32'(bz[i]), 32'(e[5*i+1]));
      check_eq({nm, "_preempt"}, 32'(pe[i]), 32'(e[5*i]));
      check_eq({nm, "_excl"},    32'(g0[i] & g1[i]), 32'd0);
    end
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step(rst);
      exp_q.push_back(model_vec());
      @(negedge clk);
      compare_out();
      #1;
    end
  endtask

  // Reset pulsed between edges: outputs must drop before the next edge.
  task automatic pulse_rst();
    @(posedge clk);
    model_step(1'b0);
    exp_q.push_back(model_vec());
    #2 rst = 1'b1;
    #1;
    check_eq("arst_gnt1", 32'(g1[0]), 32'd0);
    check_eq("arst_busy", 32'(bz[0]), 32'd0);
    check_eq("arst_sel",  32'(sl[0]), 32'd0);
    rst = 1'b0;
    model_step(1'b1);
    exp_q.delete();
    exp_q.push_back(model_vec());
    @(negedge clk);
    compare_out();
    #1;
  endtask

  task automatic set_all(input bit a, input bit b);
    for (int i = 0; i < 3; i++) begin
      r0[i] = a; r1[i] = b;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_all(0, 0);
    model_step(1'b1);
    cycle(2);
    rst = 1'b0;
    cycle(5);

    // Single requester on req1
    r1[0] = 1; cycle(4);
    r1[0] = 0; cycle(3);

    // Tie with no preemption, then owner drops
    r0[1] = 1; r1[1] = 1; cycle(3);
    r0[1] = 0; cycle(4);
    r1[1] = 0; cycle(2);

    // Preemption: req1 arrives one cycle after gnt0
    r0[0] = 1; cycle(1);
    r1[0] = 1; cycle(12);
    r0[0] = 0; cycle(2);
    r1[0] = 0; cycle(2);

    // Round-robin alternation under contention
    r0[2] = 1; r1[2] = 1; cycle(16);
    set_all(0, 0); cycle(2);

    // Async reset mid-grant with hold count at 5
    r0[0] = 0; r1[0] = 1; cycle(5);
    pulse_rst();
    set_all(1, 1); cycle(3);
    set_all(0, 0); cycle(2);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < 3; i++) begin
        r0[i] = 1'($urandom_range(0, 1));
        r1[i] = 1'($urandom_range(0, 1));
      end
      cycle(1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/decoder_1x2_arbiter.md
Name: decoder_1x2_arbiter

Overview:
- Two-requester round-robin arbiter that shares one decoded 1-bit select between two consumers.
- Internally it keeps a 1-bit owner select, `sel`, plus a `busy` enable, and drives one-hot grants as a 1-to-2 decode of `sel` gated by `busy`.
- Grant is held until the owner drops its request, or until a bounded hold time expires while the other requester waits.
- Sits between requesting blocks and a shared resource steered by a 1x2 decode.

Parameters:
- MAX_HOLD, 8, max consecutive grant cycles before forced release when the other requester waits; 0 disables preemption.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0  input  1  request from requester 0; held high for as long as it needs the resource.
- req1  input  1  request from requester 1; same rules as req0.
- gnt0  output  1  grant to requester 0; equals busy & ~sel.
- gnt1  output  1  grant to requester 1; equals busy & sel.
- sel  output  1  encoded current/last owner; holds its value when idle.
- busy  output  1  a grant is active.
- preempt  output  1  one-cycle pulse on the cycle after a forced release.

Behaviour:
- Reset (async, immediate, including mid-grant):
  - state=IDLE; gnt0=gnt1=0; busy=0; sel=0; preempt=0.
  - Priority pointer prio=0, so req0 wins the first tie; hold_cnt=0.
- All outputs are registered or decoded from registers; there is no combinational path from req to gnt.
- IDLE, at each rising edge:
  - Neither request high: stay IDLE.
  - Exactly one request high: grant that requester.
  - Both high: grant requester prio.
- On a grant: sel=owner, busy=1, hold_cnt=1, go to GRANT. Latency is one edge from request sample to grant visible.
- GRANT (owner o), evaluated at each edge in this priority order:
  1. req_o low (voluntary release): busy=0, prio=~o, hold_cnt=0, go to IDLE.
  2. MAX_HOLD!=0, hold_cnt==MAX_HOLD and req_other high (forced release): busy=0, prio=~o, hold_cnt=0, preempt=1 for one cycle, go to IDLE.
  3. Otherwise hold: hold_cnt increments, saturating at MAX_HOLD.
- Under preemption the grant is high for exactly MAX_HOLD cycles.
- Break-before-make: after any release, state is IDLE for at least one full cycle with gnt0=gnt1=0. Re-grant happens at the following edge.
- Owner drops request: the grant deasserts one cycle later, so the grant may remain high for one cycle after its request falls.
- Simultaneous request drop and hold expiry: treated as a voluntary release (preempt=0); prio still flips.
- Owner re-requests right after a release:
  - If the other requester is also high, the other wins, because prio points at it.
  - If the owner is alone, it is re-granted after the dead cycle.
- Invariants:
  - gnt0 & gnt1 == 0 always.
  - busy == gnt0 | gnt1.
  - sel is unchanged whenever busy=0.
- MAX_HOLD=0: no preemption; the owner holds indefinitely while its request is high.
- Requests must be synchronous to clk. X on req is not specified; the bench drives only 0/1.

Test Plan:
- Reset then idle: assert rst with all reqs low, release rst -> gnt0=gnt1=0, busy=0, sel=0, preempt=0 for 5 cycles.
- Single requester: req1 high at edge 2, low at edge 6 -> gnt1=1 after edges 3..6, gnt1=0 after edge 7, sel stays 1, gnt0 never high.
- Tie after reset: req0=req1=1 together at edge 2 and held, MAX_HOLD=0 -> gnt0 granted. Drop req0 at edge 5 -> one dead cycle, then gnt1=1; prio=0 afterwards.
- Preemption: MAX_HOLD=8, req0 held, req1 asserted one cycle after gnt0 -> gnt0 high exactly 8 cycles, preempt pulses 1 cycle, one idle cycle, then gnt1=1.
- Round-robin fairness: both reqs held, MAX_HOLD=3 -> grants alternate 0,1,0,1 with 3-cycle grants separated by 1 idle cycle; no cycle has both grants high.
- Async reset mid-grant: gnt1 active with hold_cnt=5, pulse rst between edges -> gnt1, busy and sel drop to 0 before the next edge. After release, req0 is granted first on a tie.
